tsn_processing_delay_gate: RTL and testbench

Per-frame residence-time check placed on each egress path of the TSN switch, directly downstream of the register block that publishes `processing_delay_max`. Each frame carries its ingress timestamp on `tuser` of its first beat. On that beat the block computes the elapsed time against `current_time`. Frames whose elapsed time exceeds `processing_delay_max` are discarded whole and counted; all other frames pass to transmission selection through a one-beat register stage.

---
 rtl/tsn_delay_gate_pkg.sv | 32 +++
 rtl/tsn_delay_axis_slice.sv | 56 +++++
 rtl/tsn_processing_delay_gate.sv | 124 ++++++++++++
 tb/tb_tsn_processing_delay_gate.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tsn_delay_gate_pkg.sv
// Shared definitions for the TSN processing-delay gate: default widths, frame FSM
// encoding and the per-frame lateness decision.
package tsn_delay_gate_pkg;

    localparam int unsigned TIMESTAMP_WIDTH_DEFAULT = 72;
    localparam int unsigned TS_CALC_WIDTH           = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } gate_state_e;

    // Operands are zero-extended to TS_CALC_WIDTH; width is the real timestamp width.
    // A wrapped difference with its top bit set is a future timestamp and never late.
    function automatic logic frame_is_late(
        input logic [TS_CALC_WIDTH-1:0] now,
        input logic [TS_CALC_WIDTH-1:0] ts,
        input logic [TS_CALC_WIDTH-1:0] limit,
        input int unsigned              width
    );
        logic [TS_CALC_WIDTH-1:0] mask;
        logic [TS_CALC_WIDTH-1:0] elapsed;
        logic                     future;
        mask    = (width >= TS_CALC_WIDTH) ? '1
                : ((TS_CALC_WIDTH'(1) << width) - TS_CALC_WIDTH'(1));
        elapsed = (now - ts) & mask;
        future  = |(elapsed & (TS_CALC_WIDTH'(1) << (width - 1)));
        return (limit != '0) && !future && (elapsed > limit);
    endfunction

endpackage

// File: rtl/tsn_delay_axis_slice.sv
// One-entry AXI-Stream register stage; accepts a new beat whenever it is empty
// or its current beat is being taken in the same cycle.
module tsn_delay_axis_slice #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned KEEP_WIDTH = 1,
    parameter int unsigned USER_WIDTH = 72
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic [KEEP_WIDTH-1:0] in_keep_i,
    input  logic [USER_WIDTH-1:0] in_user_i,
    input  logic                  in_last_i,
    output logic                  in_ready_o,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [KEEP_WIDTH-1:0] out_keep_o,
    output logic [USER_WIDTH-1:0] out_user_o,
    output logic                  out_last_o,
    input  logic                  out_ready_i
);

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [KEEP_WIDTH-1:0] keep_q;
    logic [USER_WIDTH-1:0] user_q;
    logic                  last_q;

    assign in_ready_o = !valid_q || out_ready_i;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            user_q  <= '0;
            last_q  <= 1'b0;
        end else if (in_valid_i && in_ready_o) begin
            valid_q <= 1'b1;
            data_q  <= in_data_i;
            keep_q  <= in_keep_i;
            user_q  <= in_user_i;
            last_q  <= in_last_i;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_keep_o  = keep_q;
    assign out_user_o  = user_q;
    assign out_last_o  = last_q;

endmodule

// File: rtl/tsn_processing_delay_gate.sv
// Egress residence-time gate: decides once per frame on its first beat whether to
// forward it through a register stage or discard it whole and count the drop.
module tsn_processing_delay_gate
    import tsn_delay_gate_pkg::*;
#(
    parameter int unsigned TIMESTAMP_WIDTH = TIMESTAMP_WIDTH_DEFAULT,
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned COUNT_WIDTH     = 32
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [TIMESTAMP_WIDTH-1:0] current_time,
    input  logic [TIMESTAMP_WIDTH-1:0] processing_delay_max,
    input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]    s_axis_tkeep,
    input  logic [TIMESTAMP_WIDTH-1:0] s_axis_tuser,
    input  logic                       s_axis_tlast,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic [DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]    m_axis_tkeep,
    output logic [TIMESTAMP_WIDTH-1:0] m_axis_tuser,
    output logic                       m_axis_tlast,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [COUNT_WIDTH-1:0]     drop_count,
    output logic                       drop_pulse
);

    localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;

    gate_state_e            state_q, state_d;
    logic                   rdy_en_q;
    logic [COUNT_WIDTH-1:0] drop_count_q, drop_count_d;
    logic                   drop_pulse_q, drop_pulse_d;

    logic slice_in_ready;
    logic slice_load;
    logic in_hs;
    logic late;
    logic drop_first;

    // rdy_en_q keeps s_axis_tready low while reset is asserted.
    assign s_axis_tready = rdy_en_q && ((state_q == ST_DROP) || slice_in_ready);
    assign in_hs         = s_axis_tvalid && s_axis_tready;
    assign late          = frame_is_late(TS_CALC_WIDTH'(current_time),
                                         TS_CALC_WIDTH'(s_axis_tuser),
                                         TS_CALC_WIDTH'(processing_delay_max),
                                         TIMESTAMP_WIDTH);

    always_comb begin
        state_d    = state_q;
        slice_load = 1'b0;
        drop_first = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_hs) begin
                    if (late) begin
                        drop_first = 1'b1;
                        state_d    = s_axis_tlast ? ST_IDLE : ST_DROP;
                    end else begin
                        slice_load = 1'b1;
                        state_d    = s_axis_tlast ? ST_IDLE : ST_PASS;
                    end
                end
            end
            ST_PASS: begin
                if (in_hs) begin
                    slice_load = 1'b1;
                    if (s_axis_tlast) state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (in_hs && s_axis_tlast) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        drop_pulse_d = drop_first;
        drop_count_d = drop_count_q;
        if (drop_first && (drop_count_q != '1)) drop_count_d = drop_count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            rdy_en_q     <= 1'b0;
            drop_count_q <= '0;
            drop_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rdy_en_q     <= 1'b1;
            drop_count_q <= drop_count_d;
            drop_pulse_q <= drop_pulse_d;
        end
    end

    assign drop_count = drop_count_q;
    assign drop_pulse = drop_pulse_q;

    tsn_delay_axis_slice #(
        .DATA_WIDTH (DATA_WIDTH),
        .KEEP_WIDTH (KEEP_WIDTH),
        .USER_WIDTH (TIMESTAMP_WIDTH)
    ) u_slice (
        .clk         (clk),
        .rstn        (rstn),
        .in_valid_i  (slice_load),
        .in_data_i   (s_axis_tdata),
        .in_keep_i   (s_axis_tkeep),
        .in_user_i   (s_axis_tuser),
        .in_last_i   (s_axis_tlast),
        .in_ready_o  (slice_in_ready),
        .out_valid_o (m_axis_tvalid),
        .out_data_o  (m_axis_tdata),
        .out_keep_o  (m_axis_tkeep),
        .out_user_o  (m_axis_tuser),
        .out_last_o  (m_axis_tlast),
        .out_ready_i (m_axis_tready)
    );

endmodule

// File: tb/tb_tsn_processing_delay_gate.sv
// Randomized scoreboard bench for the delay gate; a second instance with a 4-bit
// drop counter shares the stimulus to exercise counter saturation.
module tb_tsn_processing_delay_gate;

    logic        clk = 1'b0;
    logic        rstn;
    logic [71:0] current_time, processing_delay_max;
    logic [7:0]  s_axis_tdata;
    logic [0:0]  s_axis_tkeep;
    logic [71:0] s_axis_tuser;
    logic        s_axis_tlast, s_axis_tvalid, s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic [0:0]  m_axis_tkeep;
    logic [71:0] m_axis_tuser;
    logic        m_axis_tlast, m_axis_tvalid, m_axis_tready;
    logic [31:0] drop_count;
    logic        drop_pulse;

    logic        s4_tready, m4_tlast, m4_tvalid, drop_pulse4;
    logic [7:0]  m4_tdata;
    logic [0:0]  m4_tkeep;
    logic [71:0] m4_tuser;
    logic [3:0]  drop_count4;

    always #5 clk = ~clk;

    tsn_processing_delay_gate #(.TIMESTAMP_WIDTH(72), .DATA_WIDTH(8), .COUNT_WIDTH(32)) dut (
        .clk(clk), .rstn(rstn), .current_time(current_time),
        .processing_delay_max(processing_delay_max),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
        .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
        .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .drop_count(drop_count), .drop_pulse(drop_pulse)
    );

    tsn_processing_delay_gate #(.TIMESTAMP_WIDTH(72), .DATA_WIDTH(8), .COUNT_WIDTH(4)) dut4 (
        .clk(clk), .rstn(rstn), .current_time(current_time),
        .processing_delay_max(processing_delay_max),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
        .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s4_tready),
        .m_axis_tdata(m4_tdata), .m_axis_tkeep(m4_tkeep), .m_axis_tuser(m4_tuser),
        .m_axis_tlast(m4_tlast), .m_axis_tvalid(m4_tvalid), .m_axis_tready(m_axis_tready),
        .drop_count(drop_count4), .drop_pulse(drop_pulse4)
    );

    typedef struct packed {
        logic [7:0]  data;
        logic        keep;
        logic [71:0] user;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    beat_t cur_beat, prev_beat, popped;
    bit    prev_stall;
    int    checks = 0, errors = 0;
    int    exp_drops = 0, pulse_cnt = 0, pulse_cnt4 = 0, stalls = 0;
    bit    rand_rdy = 1'b0;

    assign cur_beat = {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic abort_run(input string name);
        checks++;
        errors++;
        $display("FAIL %s bound expired", name);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    function automatic logic [71:0] r72();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[71:0];
    endfunction

    // Output-side monitor: scoreboard pops, stability under stall, drop pulse counting.
    always @(negedge clk) begin
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (drop_pulse)  pulse_cnt++;
            if (drop_pulse4) pulse_cnt4++;
            if (prev_stall) begin
                check("stall_valid", 128'(m_axis_tvalid), 128'(1));
                check("stall_data", 128'(cur_beat), 128'(prev_beat));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%0h required=none", cur_beat);
                end else begin
                    popped = exp_q.pop_front();
                    check("out_beat", 128'(cur_beat), 128'(popped));
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_beat  = cur_beat;
        end
    end

    always @(posedge clk) begin
        #1;
        m_axis_tready = rand_rdy ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end

    initial begin
        #2000000;
        abort_run("global_watchdog");
    end

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [71:0] ts, input logic [71:0] now,
                              input logic [71:0] limit, input int nb, input bit mid,
                              output bit was_late);
        logic [71:0] el;
        bit          late;
        beat_t       b;
        int          n, dstall;
        el     = now - ts;
        late   = (limit != 72'd0) && (el[71] == 1'b0) && (el > limit);
        dstall = 0;
        current_time         = now;
        processing_delay_max = limit;
        for (int i = 0; i < nb; i++) begin
            b.data = 8'($urandom);
            b.keep = 1'($urandom);
            b.user = (i == 0) ? ts : r72();
            b.last = (i == nb - 1);
            s_axis_tdata  = b.data;
            s_axis_tkeep  = b.keep;
            s_axis_tuser  = b.user;
            s_axis_tlast  = b.last;
            s_axis_tvalid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!s_axis_tready) begin
                n++;
                if (n > 2000) abort_run("s_axis_tready_wait");
                @(negedge clk);
            end
            stalls += n;
            if (late && i > 0) dstall += n;
            if (!late) exp_q.push_back(b);
            @(posedge clk);
            #1;
            if (!late) check("latency_beat", 128'({m_axis_tvalid, cur_beat}), 128'({1'b1, b}));
            if (i == 0 && mid) begin
                current_time         = now + 72'h10_0000_0000;
                processing_delay_max = 72'd1;
            end
        end
        s_axis_tvalid = 1'b0;
        if (late) begin
            exp_drops++;
            check("drop_stall", 128'(dstall), 128'(0));
        end
        check("drop_count", 128'(drop_count), 128'(exp_drops));
        check("drop_count_sat4", 128'(drop_count4), 128'((exp_drops > 15) ? 15 : exp_drops));
        was_late = late;
    endtask

    task automatic random_frame(output bit was_late);
        int unsigned lim32, kind;
        logic [71:0] ts, el, lim, f;
        lim32 = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 5000);
        lim   = 72'(lim32);
        kind  = $urandom_range(0, 2);
        f     = r72();
        if (kind == 0)      el = 72'($urandom_range(0, lim32));
        else if (kind == 1) el = lim + 72'd1 + 72'($urandom_range(0, 1000));
        else                el = {1'b1, f[70:0]};
        ts = r72();
        send_frame(ts, ts + el, lim, $urandom_range(1, 5), ($urandom_range(0, 3) == 0), was_late);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0) begin
            n++;
            if (n > 2000) abort_run("drain");
            @(posedge clk);
        end
        idle_cycles(2);
        check("queue_empty", 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        bit late;
        rstn                 = 1'b0;
        m_axis_tready        = 1'b1;
        current_time         = '0;
        processing_delay_max = '0;
        s_axis_tdata         = '0;
        s_axis_tkeep         = '0;
        s_axis_tuser         = '0;
        s_axis_tlast         = 1'b0;
        s_axis_tvalid        = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out", 128'({m_axis_tvalid, cur_beat}), 128'(0));
        check("reset_tready", 128'(s_axis_tready), 128'(0));
        check("reset_counters", 128'({drop_count, drop_pulse}), 128'(0));
        rstn = 1'b1;
        idle_cycles(2);

        // Directed: on-time, late, boundary, wrap, skew, disable, mid-frame change.
        stalls = 0;
        send_frame(72'd5000, 72'd5999, 72'd1000, 4, 1'b0, late);
        check("ontime_pass", 128'(late), 128'(0));
        check("no_bubble_directed", 128'(stalls), 128'(0));
        send_frame(72'd5000, 72'd6001, 72'd1000, 4, 1'b0, late);
        check("late_drop", 128'(late), 128'(1));
        send_frame(72'd5000, 72'd6000, 72'd1000, 4, 1'b0, late);
        send_frame(72'h0 - 72'd100, 72'd50, 72'd200, 3, 1'b0, late);
        send_frame(72'd300, 72'd100, 72'd200, 2, 1'b0, late);
        send_frame(72'd0, 72'h100_0000_0000, 72'd0, 2, 1'b0, late);
        send_frame(72'd5000, 72'd5500, 72'd1000, 4, 1'b1, late);
        send_frame(72'd10, 72'd900, 72'd5, 1, 1'b0, late);
        drain();

        // Back-to-back random traffic with an always-ready sink.
        stalls = 0;
        for (int i = 0; i < 20; i++) random_frame(late);
        check("no_bubble_random", 128'(stalls), 128'(0));
        drain();

        // Random back-pressure with gaps and back-to-back frames.
        rand_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            random_frame(late);
            if ($urandom_range(0, 1) == 0) idle_cycles($urandom_range(1, 3));
        end
        rand_rdy = 1'b0;
        drain();
        check("pulse_total", 128'(pulse_cnt), 128'(exp_drops));

        // Asynchronous reset in the middle of a passing frame.
        current_time         = 72'd1100;
        processing_delay_max = 72'd1000;
        s_axis_tdata  = 8'hA5;
        s_axis_tkeep  = 1'b1;
        s_axis_tuser  = 72'd1000;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        s_axis_tdata = 8'h5A;
        #2;
        rstn = 1'b0;
        #1;
        check("async_reset_out", 128'({m_axis_tvalid, cur_beat}), 128'(0));
        check("async_reset_misc", 128'({s_axis_tready, drop_count, drop_pulse}), 128'(0));
        s_axis_tvalid = 1'b0;
        exp_q.delete();
        exp_drops  = 0;
        pulse_cnt  = 0;
        pulse_cnt4 = 0;
        @(negedge clk);
        rstn = 1'b1;
        idle_cycles(1);
        send_frame(72'd7000, 72'd7003, 72'd10, 3, 1'b0, late);
        send_frame(72'd7000, 72'd7020, 72'd10, 2, 1'b0, late);
        drain();

        // Saturation of the 4-bit counter: 16 further late frames.
        for (int i = 0; i < 16; i++)
            send_frame(72'd100, 72'd200, 72'd50, $urandom_range(1, 3), 1'b0, late);
        idle_cycles(3);
        check("sat4_hold", 128'(drop_count4), 128'(15));
        check("pulse_total32", 128'(pulse_cnt), 128'(exp_drops));
        check("pulse_total4", 128'(pulse_cnt4), 128'(exp_drops));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
